// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, the queued command record and
// the opcode legality test used by the command queue.
package alu_pkg;

    localparam int ALU_DATA_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    // The ALU treats NOP as "result 0", which makes it a safe idle value.
    localparam logic [2:0] OP_NOP = 3'b110;

    typedef struct packed {
        logic [2:0]            opcode;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
    } alu_cmd_t;

    localparam int ALU_CMD_W = $bits(alu_cmd_t);

    // Opcodes 110 and 111 never reach the ALU.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO. Owns the read/write pointers and
// the occupancy count; full/empty are registered from the next level.
// The caller guarantees push only when !full and pop only when !empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_nxt;

    // Head of the queue is presented combinationally.
    assign rdata = mem[rd_ptr];

    // Occupancy changes only when exactly one of push/pop happens.
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); flags track level_nxt.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == (AW+1)'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    // Storage array; contents need no reset because level gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Command queue and issue stage in front of the 8-bit ALU.
// Optional build macro: ALU_CMD_QUEUE_BYPASS_EN -- when defined, a legal
// command arriving at an empty queue with issue_en high goes straight to the
// ALU in the same cycle instead of through the FIFO.
//
// Handshake: a command transfers on any clock edge where in_valid and
// in_ready are both high. in_ready = !full, and a pop in the same cycle does
// not free a slot. Illegal opcodes complete the handshake but are dropped and
// set the sticky err_illegal flag.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_opcode,
    input  logic [DATA_W-1:0]      in_a,
    input  logic [DATA_W-1:0]      in_b,
    input  logic                   issue_en,
    output logic [2:0]             alu_opcode,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic                   alu_issue,
    output logic                   res_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   err_illegal
);

    alu_cmd_t in_cmd;
    alu_cmd_t head_cmd;
    logic     in_legal;
    logic     accept;
    logic     bypass;
    logic     fifo_issue;
    logic     push;

    assign in_cmd   = '{opcode: in_opcode, a: in_a, b: in_b};
    assign in_legal = is_legal_op(in_opcode);
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;

`ifdef ALU_CMD_QUEUE_BYPASS_EN
    // Empty queue: hand the incoming command straight to the ALU.
    assign bypass = empty && issue_en && in_valid && in_legal;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_issue = !empty && issue_en;
    assign push       = accept && in_legal && !bypass;
    assign alu_issue  = fifo_issue || bypass;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ALU_CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_cmd),
        .pop   (fifo_issue),
        .rdata (head_cmd),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Operand mux: bypass input, FIFO head, or the NOP idle drive.
    always_comb begin
        alu_opcode = OP_NOP;
        alu_a      = '0;
        alu_b      = '0;
        if (bypass) begin
            alu_opcode = in_cmd.opcode;
            alu_a      = in_cmd.a;
            alu_b      = in_cmd.b;
        end else if (fifo_issue) begin
            alu_opcode = head_cmd.opcode;
            alu_a      = head_cmd.a;
            alu_b      = head_cmd.b;
        end
    end

    // res_valid follows issue by one cycle, matching the ALU's output register;
    // an issue during reset is squashed. err_illegal is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid   <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            res_valid <= alu_issue;
            if (accept && !in_legal) begin
                err_illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Testbench for alu_cmd_queue: a cycle model of the queue plus a registered
// ALU model downstream; commands are scoreboarded from accept to issue and
// results from issue to res_valid.
module tb_alu_cmd_queue;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_opcode = 3'd0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        issue_en = 1'b0;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_issue;
    logic        res_valid;
    logic [AW:0] level;
    logic        full;
    logic        empty;
    logic        err_illegal;

    always #5 clk = ~clk;

    alu_cmd_queue #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .issue_en    (issue_en),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_issue   (alu_issue),
        .res_valid   (res_valid),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .err_illegal (err_illegal)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Result word: {carry, zero, result[7:0]}
    function automatic logic [9:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = 9'd0;
        case (op)
            3'd0:    s = {1'b0, a} + {1'b0, b};
            3'd1:    s = {1'b0, a} - {1'b0, b};
            3'd2:    s = {1'b0, a & b};
            3'd3:    s = {1'b0, a | b};
            3'd4:    s = {1'b0, a ^ b};
            3'd5:    s = {1'b0, ~a};
            default: s = 9'd0;
        endcase
        return {s[8], (s[7:0] == 8'd0), s[7:0]};
    endfunction

    // Registered ALU standing in for the real one.
    logic [9:0] alu_word = 10'd0;
    always @(posedge clk) alu_word <= alu_fn(alu_opcode, alu_a, alu_b);

    // ---------------- scoreboard / model ----------------
    logic [18:0] exp_q[$];
    logic [9:0]  res_q[$];
    int   mdl_level = 0;
    logic mdl_res_valid = 1'b0;
    logic mdl_err = 1'b0;
    logic mdl_valid = 1'b0;
    logic acc_flag = 1'b0;

    always @(negedge clk) begin
        logic m_ready, m_legal, m_acc, m_fifo_issue, m_byp, m_issue, m_push;
        logic [18:0] exp_cmd;
        logic [9:0]  exp_res;
        m_ready      = (mdl_level != DEPTH);
        m_legal      = (in_opcode <= 3'd5);
        m_acc        = in_valid && m_ready;
        m_fifo_issue = (mdl_level != 0) && issue_en;
`ifdef ALU_CMD_QUEUE_BYPASS_EN
        m_byp = (mdl_level == 0) && issue_en && in_valid && m_legal;
`else
        m_byp = 1'b0;
`endif
        m_issue  = m_fifo_issue || m_byp;
        acc_flag = m_acc;
        exp_cmd  = 19'd0;
        if (mdl_valid) begin
            check("in_ready", in_ready, m_ready);
            check("level", level, mdl_level);
            check("full", full, mdl_level == DEPTH);
            check("empty", empty, mdl_level == 0);
            check("alu_issue", alu_issue, m_issue);
            check("res_valid", res_valid, mdl_res_valid);
            check("err_illegal", err_illegal, mdl_err);
            if (m_issue) begin
                if (m_byp) exp_cmd = {in_opcode, in_a, in_b};
                else if (exp_q.size() > 0) exp_cmd = exp_q.pop_front();
                check("issue_cmd", {alu_opcode, alu_a, alu_b}, exp_cmd);
            end else begin
                check("idle_drive", {alu_opcode, alu_a, alu_b}, {OP_NOP, 8'h00, 8'h00});
            end
            if (mdl_res_valid && res_q.size() > 0) begin
                exp_res = res_q.pop_front();
                check("alu_result", alu_word, exp_res);
            end
        end
        // advance model to the state after the coming posedge
        if (rst) begin
            mdl_level     = 0;
            exp_q.delete();
            res_q.delete();
            mdl_res_valid = 1'b0;
            mdl_err       = 1'b0;
            mdl_valid     = 1'b1;
        end else begin
            if (m_issue) res_q.push_back(alu_fn(exp_cmd[18:16], exp_cmd[15:8], exp_cmd[7:0]));
            mdl_res_valid = m_issue;
            if (m_acc && !m_legal) mdl_err = 1'b1;
            m_push = m_acc && m_legal && !m_byp;
            if (m_push) exp_q.push_back({in_opcode, in_a, in_b});
            mdl_level = mdl_level + int'(m_push) - int'(m_fifo_issue);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic got;
        got       = 1'b0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk);
            got = acc_flag;
        end
        #1;
        in_valid = 1'b0;
        check("send_accept", got, 1'b1);
    endtask

    task automatic drain();
        logic done;
        done     = 1'b0;
        in_valid = 1'b0;
        issue_en = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(posedge clk);
            done = (mdl_level == 0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_empty", empty, 1'b1);
        check("rst_level", level, 0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_alu_opcode", alu_opcode, OP_NOP);
        check("rst_err", err_illegal, 1'b0);
        @(posedge clk);
        #1;

`ifdef ALU_CMD_QUEUE_BYPASS_EN
        // Bypass: SUB 0-1 issues in the accept cycle.
        issue_en  = 1'b1;
        in_valid  = 1'b1;
        in_opcode = OP_SUB;
        in_a      = 8'h00;
        in_b      = 8'h01;
        @(negedge clk);
        check("byp_issue_same_cycle", alu_issue, 1'b1);
        check("byp_opcode", alu_opcode, OP_SUB);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("byp_res_valid", res_valid, 1'b1);
        check("byp_result", alu_word, 10'h2FF);
        @(posedge clk);
        #1;
`else
        // Single ADD: issue one cycle after accept, result one cycle later.
        issue_en = 1'b1;
        send(OP_ADD, 8'h0F, 8'h01);
        @(negedge clk);
        check("add_issue_lat1", alu_issue, 1'b1);
        @(negedge clk);
        check("add_res_valid", res_valid, 1'b1);
        check("add_result", alu_word, 10'h010);
        @(posedge clk);
        #1;
`endif

        // Fill with issue frozen, then a held 5th command.
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(3'($urandom_range(0, 5)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        in_valid  = 1'b1;
        in_opcode = OP_XOR;
        in_a      = 8'h5A;
        in_b      = 8'hC3;
        @(negedge clk);
        check("fill_full", full, 1'b1);
        check("fill_ready", in_ready, 1'b0);
        check("fill_level", level, 4);
        @(posedge clk);
        #1 issue_en = 1'b1;
        @(negedge clk);
        check("full_pop_ready", in_ready, 1'b0);
        check("full_pop_issue", alu_issue, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("full_pop_level3", level, 3);
        check("full_pop_ready_next", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("push_pop_level3", level, 3);
        drain();

        // Illegal opcode: accepted, dropped, sticky error.
        issue_en = 1'b0;
        send(3'b111, 8'h12, 8'h34);
        @(negedge clk);
        check("illegal_level", level, 0);
        check("illegal_err", err_illegal, 1'b1);
        @(posedge clk);
        #1 issue_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(3'($urandom_range(0, 5)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        drain();
        check("err_sticky", err_illegal, 1'b1);

        // Random traffic with random issue gating and occasional illegal ops.
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_opcode = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            in_a      = 8'($urandom_range(0, 255));
            in_b      = 8'($urandom_range(0, 255));
            issue_en  = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        // Reset mid-stream: queued work is flushed, the reset-cycle issue yields no result.
        issue_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(OP_OR, 8'(i), 8'h80);
        end
        issue_en = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_empty", empty, 1'b1);
        check("midrst_level", level, 0);
        check("midrst_res_valid", res_valid, 1'b0);
        check("midrst_err", err_illegal, 1'b0);
        @(posedge clk);
        #1;
        send(OP_AND, 8'hF0, 8'h3C);
        send(OP_NOT, 8'h00, 8'h00);
        drain();

        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
